// File: rtl/tl_ul_reg_slave.sv
// rtl/tl_ul_reg_slave.sv - TL-UL register-file slave with programmable response latency
module tl_ul_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MASK_WIDTH = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH = 3,
    parameter int                    SRC_WIDTH  = 2,
    parameter int                    SINK_WIDTH = 1,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                    LATENCY    = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [2:0]                     a_opcode,
    input  logic [2:0]                     a_param,
    input  logic [SIZE_WIDTH-1:0]          a_size,
    input  logic [SRC_WIDTH-1:0]           a_source,
    input  logic [ADDR_WIDTH-1:0]          a_address,
    input  logic [MASK_WIDTH-1:0]          a_mask,
    input  logic [DATA_WIDTH-1:0]          a_data,
    output logic                           d_valid,
    input  logic                           d_ready,
    output logic [2:0]                     d_opcode,
    output logic [2:0]                     d_param,
    output logic [SIZE_WIDTH-1:0]          d_size,
    output logic [SRC_WIDTH-1:0]           d_source,
    output logic [SINK_WIDTH-1:0]          d_sink,
    output logic [DATA_WIDTH-1:0]          d_data,
    output logic                           d_error,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

    localparam int                    IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] REG_SPAN = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [2:0]            OP_PUT_FULL = 3'd0;
    localparam logic [2:0]            OP_PUT_PART = 3'd1;
    localparam logic [2:0]            OP_GET      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    get_q;
    logic                    err_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic [SRC_WIDTH-1:0]    source_q;
    logic [IDX_W-1:0]        idx_q;
    logic [MASK_WIDTH-1:0]   mask_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   reg_q [NUM_REGS];

    logic                    accept;
    logic                    commit;
    logic [ADDR_WIDTH:0]     offset_ext;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    below_base;
    logic                    in_range;
    logic                    op_ok;
    logic                    size_ok;
    logic                    misaligned;
    logic                    a_err;
    logic [IDX_W-1:0]        a_idx;
    logic                    unused_a_param;

    assign unused_a_param = ^a_param;

    // Extra MSB on the subtraction acts as the borrow, so "below base" needs no compare against a constant.
    assign offset_ext = {1'b0, a_address} - {1'b0, BASE_ADDR};
    assign below_base = offset_ext[ADDR_WIDTH];
    assign offset     = offset_ext[ADDR_WIDTH-1:0];
    assign in_range   = !below_base && (offset < REG_SPAN);
    assign op_ok      = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART) || (a_opcode == OP_GET);
    assign size_ok    = (a_size <= SIZE_WIDTH'(2));
    assign a_idx      = offset[IDX_W+1:2];

    always_comb begin
        misaligned = 1'b0;
        if (a_size == SIZE_WIDTH'(1)) begin
            misaligned = a_address[0];
        end else if (a_size == SIZE_WIDTH'(2)) begin
            misaligned = |a_address[1:0];
        end
    end

    assign a_err  = !op_ok || !size_ok || misaligned || !in_range;
    assign accept = a_valid && (state_q == ST_IDLE);
    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every request passes through WAIT; the counter gives LATENCY extra cycles before RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (a_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            get_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            source_q <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                get_q    <= (a_opcode == OP_GET);
                err_q    <= a_err;
                size_q   <= a_size;
                source_q <= a_source;
                idx_q    <= a_idx;
                mask_q   <= a_mask;
                wdata_q  <= a_data;
            end
            // Register write and read capture share the edge that enters RESP.
            if (commit) begin
                rdata_q <= (get_q && !err_q) ? reg_q[idx_q] : '0;
                if (!get_q && !err_q) begin
                    for (int b = 0; b < MASK_WIDTH; b++) begin
                        if (mask_q[b]) begin
                            reg_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        regs_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[DATA_WIDTH*i +: DATA_WIDTH] = reg_q[i];
        end
    end

    assign a_ready  = (state_q == ST_IDLE);
    assign d_valid  = (state_q == ST_RESP);
    assign d_opcode = {2'b00, get_q};
    assign d_param  = 3'd0;
    assign d_size   = size_q;
    assign d_source = source_q;
    assign d_sink   = '0;
    assign d_data   = rdata_q;
    assign d_error  = err_q;

endmodule

// File: tb/tb_tl_ul_reg_slave.sv
// tb/tb_tl_ul_reg_slave.sv - randomized bench for tl_ul_reg_slave against a transaction-level model
module tb_tl_ul_reg_slave;
    localparam int NR = 8;
    localparam int NI = 2;
    localparam int RW = NR * 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          a_valid   [NI];
    logic          a_ready   [NI];
    logic [2:0]    a_opcode  [NI];
    logic [2:0]    a_param   [NI];
    logic [2:0]    a_size    [NI];
    logic [1:0]    a_source  [NI];
    logic [31:0]   a_address [NI];
    logic [3:0]    a_mask    [NI];
    logic [31:0]   a_data    [NI];
    logic          d_valid   [NI];
    logic          d_ready   [NI];
    logic [2:0]    d_opcode  [NI];
    logic [2:0]    d_param   [NI];
    logic [2:0]    d_size    [NI];
    logic [1:0]    d_source  [NI];
    logic [0:0]    d_sink    [NI];
    logic [31:0]   d_data    [NI];
    logic          d_error   [NI];
    logic [RW-1:0] regs_q    [NI];

    tl_ul_reg_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_opcode(a_opcode[0]), .a_param(a_param[0]),
        .a_size(a_size[0]), .a_source(a_source[0]), .a_address(a_address[0]), .a_mask(a_mask[0]),
        .a_data(a_data[0]), .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_opcode(d_opcode[0]),
        .d_param(d_param[0]), .d_size(d_size[0]), .d_source(d_source[0]), .d_sink(d_sink[0]),
        .d_data(d_data[0]), .d_error(d_error[0]), .regs_q(regs_q[0])
    );

    tl_ul_reg_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0000_0040), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_opcode(a_opcode[1]), .a_param(a_param[1]),
        .a_size(a_size[1]), .a_source(a_source[1]), .a_address(a_address[1]), .a_mask(a_mask[1]),
        .a_data(a_data[1]), .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_opcode(d_opcode[1]),
        .d_param(d_param[1]), .d_size(d_size[1]), .d_source(d_source[1]), .d_sink(d_sink[1]),
        .d_data(d_data[1]), .d_error(d_error[1]), .regs_q(regs_q[1])
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] base_of(int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0000_0040;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic chk(int k, string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL dut%0d %s: got %0h want %0h (cyc %0d)", k, nm, act, exp, cyc);
        end
    endtask

    // Model: register contents plus the one outstanding transaction per instance.
    logic [31:0] mem       [NI][NR];
    int          phase     [NI];
    int          commit_at [NI];
    logic        e_get     [NI];
    logic        e_err     [NI];
    logic [2:0]  e_size    [NI];
    logic [1:0]  e_src     [NI];
    logic [31:0] e_data    [NI];
    int          w_idx     [NI];
    logic [3:0]  w_mask    [NI];
    logic [31:0] w_data    [NI];

    function automatic logic model_err(int k, logic [2:0] op, logic [2:0] sz, logic [31:0] addr);
        longint a = longint'(addr);
        longint b = longint'(base_of(k));
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if ((a % (longint'(1) << sz)) != 0) return 1'b1;
        if (a < b || a >= b + 4 * NR) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] flat(int k);
        logic [RW-1:0] f = '0;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = mem[k][i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NI; k++) begin
                phase[k] = 0;
                for (int i = 0; i < NR; i++) mem[k][i] = 32'h0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (phase[k] == 1 && cyc >= commit_at[k]) begin
                    e_data[k] = 32'h0;
                    if (!e_err[k] && e_get[k]) begin
                        e_data[k] = mem[k][w_idx[k]];
                    end else if (!e_err[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (w_mask[k][b]) mem[k][w_idx[k]][8*b +: 8] = w_data[k][8*b +: 8];
                    end
                    phase[k] = 2;
                end
                chk(k, "a_ready", RW'(a_ready[k]), RW'(phase[k] == 0));
                chk(k, "d_valid", RW'(d_valid[k]), RW'(phase[k] == 2));
                if (phase[k] == 2) begin
                    chk(k, "d_opcode", RW'(d_opcode[k]), RW'(e_get[k] ? 3'd1 : 3'd0));
                    chk(k, "d_error",  RW'(d_error[k]),  RW'(e_err[k]));
                    chk(k, "d_size",   RW'(d_size[k]),   RW'(e_size[k]));
                    chk(k, "d_source", RW'(d_source[k]), RW'(e_src[k]));
                    chk(k, "d_data",   RW'(d_data[k]),   RW'(e_data[k]));
                    chk(k, "d_param",  RW'(d_param[k]),  RW'(0));
                    chk(k, "d_sink",   RW'(d_sink[k]),   RW'(0));
                end
                chk(k, "regs_q", regs_q[k], flat(k));
                if (phase[k] == 2) begin
                    if (d_ready[k]) phase[k] = 0;
                end else if (phase[k] == 0 && a_valid[k]) begin
                    e_get[k]     = (a_opcode[k] == 3'd4);
                    e_err[k]     = model_err(k, a_opcode[k], a_size[k], a_address[k]);
                    e_size[k]    = a_size[k];
                    e_src[k]     = a_source[k];
                    w_idx[k]     = int'((a_address[k] - base_of(k)) >> 2);
                    w_mask[k]    = a_mask[k];
                    w_data[k]    = a_data[k];
                    commit_at[k] = cyc + 2 + lat_of(k);
                    phase[k]     = 1;
                end
            end
        end
    end

    int          acc, acc2, vld, hs;
    logic [2:0]  rop;
    logic        rerr;
    logic [31:0] rdata;
    logic [1:0]  rsrc;

    task automatic issue(int k, logic [2:0] op, logic [2:0] sz, logic [1:0] src,
                         logic [31:0] addr, logic [3:0] mask, logic [31:0] data);
        @(posedge clk);
        #1;
        a_opcode[k]  = op;
        a_param[k]   = 3'($urandom_range(0, 7));
        a_size[k]    = sz;
        a_source[k]  = src;
        a_address[k] = addr;
        a_mask[k]    = mask;
        a_data[k]    = data;
        a_valid[k]   = 1'b1;
    endtask

    task automatic wait_accept(int k);
        int n = 0;
        acc = -1;
        while (n < 64) begin
            @(negedge clk);
            if (a_ready[k]) break;
            n++;
        end
        if (n >= 64) chk(k, "accept_timeout", RW'(0), RW'(1));
        else acc = cyc + 1;
        @(posedge clk);
        #1;
        a_valid[k] = 1'b0;
    endtask

    task automatic wait_dvalid(int k);
        int n = 0;
        vld = -1;
        while (n < 64) begin
            @(negedge clk);
            if (d_valid[k]) break;
            n++;
        end
        if (n >= 64) chk(k, "resp_timeout", RW'(0), RW'(1));
        else begin
            vld   = cyc;
            rop   = d_opcode[k];
            rerr  = d_error[k];
            rdata = d_data[k];
            rsrc  = d_source[k];
        end
    endtask

    task automatic txn(int k, logic [2:0] op, logic [2:0] sz, logic [1:0] src,
                       logic [31:0] addr, logic [3:0] mask, logic [31:0] data, int stall);
        issue(k, op, sz, src, addr, mask, data);
        wait_accept(k);
        d_ready[k] = (stall == 0);
        wait_dvalid(k);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            @(posedge clk);
            #1;
            d_ready[k] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        d_ready[k] = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            a_valid[k] = 1'b0; a_opcode[k] = 3'd0; a_param[k] = 3'd0; a_size[k] = 3'd0;
            a_source[k] = 2'd0; a_address[k] = 32'h0; a_mask[k] = 4'h0; a_data[k] = 32'h0;
            d_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk(k, "rst_a_ready",  RW'(a_ready[k]),  RW'(1));
            chk(k, "rst_d_valid",  RW'(d_valid[k]),  RW'(0));
            chk(k, "rst_d_opcode", RW'(d_opcode[k]), RW'(0));
            chk(k, "rst_d_size",   RW'(d_size[k]),   RW'(0));
            chk(k, "rst_d_source", RW'(d_source[k]), RW'(0));
            chk(k, "rst_d_data",   RW'(d_data[k]),   RW'(0));
            chk(k, "rst_d_error",  RW'(d_error[k]),  RW'(0));
            chk(k, "rst_regs_q",   regs_q[k],        RW'(0));
        end
        #1 reset_n = 1'b1;

        txn(0, 3'd0, 3'd2, 2'd1, 32'h4, 4'hF, 32'hDEADBEEF, 0);
        chk(0, "put_latency", RW'(vld - acc), RW'(2));
        chk(0, "put_opcode",  RW'(rop),  RW'(0));
        chk(0, "put_error",   RW'(rerr), RW'(0));
        chk(0, "reg1_full",   RW'(regs_q[0][63:32]), RW'(32'hDEADBEEF));
        txn(0, 3'd4, 3'd2, 2'd0, 32'h4, 4'hF, 32'h0, 0);
        chk(0, "get_opcode",  RW'(rop),   RW'(1));
        chk(0, "get_data",    RW'(rdata), RW'(32'hDEADBEEF));

        txn(0, 3'd1, 3'd2, 2'd0, 32'h4, 4'h5, 32'h11223344, 0);
        chk(0, "partial_error", RW'(rerr), RW'(0));
        chk(0, "reg1_partial",  RW'(regs_q[0][63:32]), RW'(32'hDE22BE44));

        txn(0, 3'd4, 3'd2, 2'd2, 32'h20, 4'hF, 32'h0, 0);
        chk(0, "oob_opcode", RW'(rop),   RW'(1));
        chk(0, "oob_error",  RW'(rerr),  RW'(1));
        chk(0, "oob_data",   RW'(rdata), RW'(0));
        chk(0, "oob_source", RW'(rsrc),  RW'(2));
        txn(0, 3'd0, 3'd2, 2'd0, 32'h22, 4'hF, 32'hFFFFFFFF, 1);
        chk(0, "misalign_error", RW'(rerr), RW'(1));
        chk(0, "misalign_noreg", RW'(regs_q[0][63:0]), RW'(64'hDE22BE44_00000000));
        txn(0, 3'd6, 3'd2, 2'd0, 32'h8, 4'hF, 32'h12345678, 0);
        chk(0, "badop_error", RW'(rerr), RW'(1));

        // Backpressure: hold the response, present a second request meanwhile.
        d_ready[0] = 1'b0;
        issue(0, 3'd4, 3'd2, 2'd3, 32'h4, 4'hF, 32'h0);
        wait_accept(0);
        wait_dvalid(0);
        @(posedge clk);
        #1;
        a_opcode[0] = 3'd0; a_size[0] = 3'd2; a_source[0] = 2'd1;
        a_address[0] = 32'h8; a_mask[0] = 4'hF; a_data[0] = 32'hCAFEF00D; a_valid[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        d_ready[0] = 1'b1;
        hs = cyc;
        wait_accept(0);
        chk(0, "bp_accept_edge", RW'(acc), RW'(hs + 2));
        wait_dvalid(0);
        @(posedge clk);
        #1;
        chk(0, "bp_put_reg2", RW'(regs_q[0][95:64]), RW'(32'hCAFEF00D));

        txn(1, 3'd0, 3'd2, 2'd0, 32'h44, 4'hF, 32'hA5A5_5A5A, 0);
        chk(1, "lat0_latency", RW'(vld - acc), RW'(1));
        txn(1, 3'd4, 3'd0, 2'd3, 32'h3C, 4'h1, 32'h0, 0);
        chk(1, "below_base_error", RW'(rerr), RW'(1));
        for (int i = 0; i < 3; i++) begin
            txn(1, 3'd4, 3'd2, 2'(i), 32'h44, 4'hF, 32'h0, 0);
            chk(1, "b2b_get_data", RW'(rdata), RW'(32'hA5A5_5A5A));
        end

        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 40; t++) begin
                int         r = $urandom_range(0, 9);
                logic [2:0] op;
                logic [2:0] sz;
                op = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom_range(5, 7));
                sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
                txn(k, op, sz, 2'($urandom_range(0, 3)),
                    base_of(k) + 32'($urandom_range(0, 4 * NR + 7)) - 32'd4,
                    4'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 2)));
            end
        end

        // Reset while the write is waiting out its latency.
        issue(0, 3'd0, 3'd2, 2'd0, 32'hC, 4'hF, 32'h5555AAAA);
        wait_accept(0);
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk(0, "midrst_d_valid", RW'(d_valid[0]), RW'(0));
        chk(0, "midrst_regs_q",  regs_q[0],       RW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk(0, "postrst_d_valid", RW'(d_valid[0]), RW'(0));
        end
        chk(0, "postrst_a_ready", RW'(a_ready[0]), RW'(1));
        chk(0, "postrst_regs_q",  regs_q[0],       RW'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
